// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline register with a one-entry skid buffer, flush and hold.
// Latency: an accepted fetch shows on the outputs after the accepting edge when the main slot is free or popping.
// Backpressure: in_ready_o is low only when the skid slot holds an entry; it comes straight from state flops.
module if_id_skid_stage #(
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INT_W    = 8,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic [INT_W-1:0]  int_flag_i,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [INT_W-1:0]  int_flag_o
);

  // One fetched instruction with everything that travels alongside it.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] addr;
    logic [INT_W-1:0]  flag;
  } entry_t;

  // EMPTY: nothing held. ONE: main slot valid. FULL: main and skid slots valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  entry_t main_q;
  entry_t skid_q;
  entry_t in_dat;

  logic push;
  logic pop;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  assign in_dat = {inst_i, inst_addr_i, int_flag_i};

  // Both handshake flags decode only the state register, so ready never
  // depends combinationally on decode-side stall or flush.
  assign in_ready_o  = (state_q != ST_FULL);
  assign out_valid_o = (state_q != ST_EMPTY);

  // hold_i looks exactly like decode not being ready.
  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i & ~hold_i;

  // Next-state and slot-load decisions; flush discards everything including
  // a concurrent push, while a concurrent pop has already been taken by decode.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            load_main_in = 1'b1;
            state_d      = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            load_main_in = 1'b1;
          end else if (push) begin
            load_skid = 1'b1;
            state_d   = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready_o is low here, so only the skid-to-main shift can happen.
          if (pop) begin
            load_main_skid = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Occupancy register; reset empties both slots just like a flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload registers carry no reset: contents of an empty slot are never
  // visible because the outputs are masked by out_valid_o.
  always_ff @(posedge clk) begin
    if (load_main_in) begin
      main_q <= in_dat;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
    if (load_skid) begin
      skid_q <= in_dat;
    end
  end

  // Present the main slot, or a harmless NOP with zeroed side info when empty.
  always_comb begin
    inst_o      = NOP_INST;
    inst_addr_o = '0;
    int_flag_o  = '0;
    if (out_valid_o) begin
      inst_o      = main_q.inst;
      inst_addr_o = main_q.addr;
      int_flag_o  = main_q.flag;
    end
  end

endmodule

// File: tb/tb_if_id_skid_stage.sv
module tb_if_id_skid_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic [7:0]  int_flag_i;
  logic        flush_i;
  logic        hold_i;
  logic        out_ready_i;
  logic        out_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [7:0]  int_flag_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_id_skid_stage #(
    .INST_W(32), .ADDR_W(32), .INT_W(8), .NOP_INST(NOP)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .int_flag_i(int_flag_i),
    .flush_i(flush_i), .hold_i(hold_i), .out_ready_i(out_ready_i),
    .out_valid_o(out_valid_o), .inst_o(inst_o),
    .inst_addr_o(inst_addr_o), .int_flag_o(int_flag_o)
  );

  // Reference model: a FIFO of capacity two, described as a queue.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [7:0]  flag;
  } ent_t;

  ent_t q[$];
  int   model_pops = 0;
  int   dut_pops   = 0;
  bit   m_pop;
  bit   m_push;

  // Advance the reference queue on each edge using the inputs held over it.
  always @(posedge clk) begin
    if (!rst || flush_i) begin
      if (rst && q.size() != 0 && out_ready_i && !hold_i) model_pops++;
      q.delete();
    end else begin
      m_pop  = (q.size() != 0) && out_ready_i && !hold_i;
      m_push = in_valid_i && (q.size() < 2);
      if (m_pop) begin
        void'(q.pop_front());
        model_pops++;
      end
      if (m_push) q.push_back({inst_i, inst_addr_i, int_flag_i});
    end
  end

  // Count handshakes the DUT actually offers to decode.
  always @(posedge clk) begin
    if (rst && out_valid_o && out_ready_i && !hold_i) dut_pops++;
  end

  function automatic ent_t exp_ent();
    ent_t e;
    if (q.size() == 0) begin
      e.inst = NOP;
      e.addr = '0;
      e.flag = '0;
    end else begin
      e = q[0];
    end
    return e;
  endfunction

  function automatic logic [31:0] inst_of(input logic [31:0] addr);
    return {addr[29:0], 2'b11} ^ 32'h5500_0000;
  endfunction

  task automatic drive(input logic v, input logic [31:0] addr, input logic [7:0] fl,
                       input logic rdy, input logic hd, input logic fsh);
    in_valid_i  = v;
    inst_addr_i = addr;
    inst_i      = inst_of(addr);
    int_flag_i  = fl;
    out_ready_i = rdy;
    hold_i      = hd;
    flush_i     = fsh;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || inst_o !== NOP ||
        inst_addr_o !== 32'h0 || int_flag_o !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b ready=%b inst=%h addr=%h flag=%h want 0 1 %h 0 0",
               out_valid_o, in_ready_o, inst_o, inst_addr_o, int_flag_o, NOP);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(4 * i), 8'h0, 1'b1, 1'b0, 1'b0);
      tick();
      n_checks++;
      if (out_valid_o !== 1'b1 || inst_addr_o !== 32'(4 * i) ||
          inst_o !== inst_of(32'(4 * i)) || in_ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL stream[%0d]: valid=%b addr=%h inst=%h ready=%b want 1 %h %h 1",
                 i, out_valid_o, inst_addr_o, inst_o, in_ready_o, 4 * i, inst_of(32'(4 * i)));
      end
    end
    drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (out_valid_o !== 1'b0 || inst_o !== NOP) begin
      n_fail++;
      $display("FAIL stream_drain: valid=%b inst=%h want 0 %h", out_valid_o, inst_o, NOP);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'h10, 8'h0, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (inst_addr_o !== 32'h10 || in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first: addr=%h ready=%b want 10 1", inst_addr_o, in_ready_o);
    end
    drive(1'b1, 32'h14, 8'h0, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (inst_addr_o !== 32'h10 || in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: addr=%h ready=%b valid=%b want 10 0 1",
               inst_addr_o, in_ready_o, out_valid_o);
    end
    drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (inst_addr_o !== 32'h14 || inst_o !== inst_of(32'h14) || in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second: addr=%h inst=%h ready=%b want 14 %h 1",
               inst_addr_o, inst_o, in_ready_o, inst_of(32'h14));
    end
    tick();
    n_checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_empty: valid=%b ready=%b want 0 1", out_valid_o, in_ready_o);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h20, 8'h0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h24, 8'h0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h28, 8'h0, 1'b0, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (out_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0 || in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full: valid=%b inst=%h addr=%h ready=%b want 0 %h 0 1",
               out_valid_o, inst_o, inst_addr_o, in_ready_o, NOP);
    end
    drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_28: valid=%b addr=%h want 0", out_valid_o, inst_addr_o);
    end
    // Flush from ONE while a push is actually accepted: the push must vanish.
    drive(1'b1, 32'h50, 8'h0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h54, 8'h0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_push_dropped: valid=%b addr=%h want 0", out_valid_o, inst_addr_o);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 32'h30, 8'h0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid_o !== 1'b1 || inst_addr_o !== 32'h30) begin
        n_fail++;
        $display("FAIL hold_keep[%0d]: valid=%b addr=%h want 1 30", i, out_valid_o, inst_addr_o);
      end
      tick();
    end
    hold_i = 1'b0;
    tick();
    n_checks++;
    if (out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: valid=%b addr=%h want 0", out_valid_o, inst_addr_o);
    end
    tick();
    n_checks++;
    if (out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_no_dup: valid=%b addr=%h want 0", out_valid_o, inst_addr_o);
    end
  endtask

  task automatic test_int_flag();
    drive(1'b1, 32'h40, 8'h04, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (int_flag_o !== 8'h04 || inst_addr_o !== 32'h40) begin
        n_fail++;
        $display("FAIL int_flag[%0d]: flag=%h addr=%h want 04 40", i, int_flag_o, inst_addr_o);
      end
      tick();
    end
    out_ready_i = 1'b1;
    tick();
    n_checks++;
    if (int_flag_o !== 8'h00 || out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL int_flag_clear: flag=%h valid=%b want 00 0", int_flag_o, out_valid_o);
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 32'h60, 8'h11, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h64, 8'h22, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (in_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_full: ready=%b want 0", in_ready_o);
    end
    rst = 1'b0;
    drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    n_checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || inst_o !== NOP ||
        inst_addr_o !== 32'h0 || int_flag_o !== 8'h0) begin
      n_fail++;
      $display("FAIL rst_mid: valid=%b ready=%b inst=%h addr=%h flag=%h want 0 1 %h 0 0",
               out_valid_o, in_ready_o, inst_o, inst_addr_o, int_flag_o, NOP);
    end
    out_ready_i = 1'b1;
    tick();
    n_checks++;
    if (out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_dropped: valid=%b addr=%h want 0", out_valid_o, inst_addr_o);
    end
  endtask

  task automatic test_random();
    ent_t e;
    int   errs = 0;
    model_pops = 0;
    dut_pops   = 0;
    for (int i = 0; i < 10000; i++) begin
      in_valid_i  = ($urandom_range(0, 9) < 7);
      inst_i      = $urandom;
      inst_addr_i = $urandom;
      int_flag_i  = 8'($urandom);
      out_ready_i = ($urandom_range(0, 9) < 6);
      hold_i      = ($urandom_range(0, 9) == 0);
      flush_i     = ($urandom_range(0, 39) == 0);
      rst         = ($urandom_range(0, 199) != 0);
      tick();
      e = exp_ent();
      n_checks++;
      if (out_valid_o !== (q.size() != 0) || in_ready_o !== (q.size() < 2) ||
          inst_o !== e.inst || inst_addr_o !== e.addr || int_flag_o !== e.flag) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: valid=%b ready=%b inst=%h addr=%h flag=%h want %b %b %h %h %h",
                   i, out_valid_o, in_ready_o, inst_o, inst_addr_o, int_flag_o,
                   q.size() != 0, q.size() < 2, e.inst, e.addr, e.flag);
      end
    end
    rst = 1'b1;
    drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (dut_pops !== model_pops) begin
      n_fail++;
      $display("FAIL random_delivered: dut=%0d model=%0d", dut_pops, model_pops);
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_hold();
    test_int_flag();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
